// File: rtl/latch_bank_write_sequencer.sv
// Round-robin write sequencer for a bank of level-sensitive latch words.
// Each write runs SETUP -> PULSE -> HOLD so latch D is stable around the enable.
module latch_bank_write_sequencer #(
  parameter int unsigned WORDS     = 8,
  parameter int unsigned AW        = 3,
  parameter int unsigned DW        = 8,
  parameter int unsigned PULSE_CYC = 1,
  parameter int unsigned HOLD_CYC  = 1
) (
  input  logic             CLK,
  input  logic             RN,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [AW-1:0]    req0_addr,
  input  logic [DW-1:0]    req0_data,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [AW-1:0]    req1_addr,
  input  logic [DW-1:0]    req1_data,
  output logic [WORDS-1:0] lat_E,
  output logic [DW-1:0]    lat_D,
  output logic             busy,
  output logic             grant_id,
  output logic             err_oor
);

  localparam int unsigned MAXC = (PULSE_CYC > HOLD_CYC) ? PULSE_CYC : HOLD_CYC;
  localparam int unsigned CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, PULSE, HOLD} state_t;

  state_t          state;
  logic            rr_pref;
  logic [AW-1:0]   cap_addr;
  logic            cap_oor;
  logic [CW-1:0]   cnt;

  logic            take0;
  logic            take1;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_data;
  logic            sel_oor;

  // rr_pref = 0 favours requester 0 when both are valid.
  always_comb begin
    req0_ready = RN && (state == IDLE) && req0_valid && (!req1_valid || !rr_pref);
    req1_ready = RN && (state == IDLE) && req1_valid && (!req0_valid || rr_pref);
    take0      = req0_valid && req0_ready;
    take1      = req1_valid && req1_ready;
    sel_addr   = take1 ? req1_addr : req0_addr;
    sel_data   = take1 ? req1_data : req0_data;
    sel_oor    = 32'(sel_addr) >= WORDS;
  end

  assign busy = (state != IDLE);

  // lat_D is loaded on the acceptance edge so it is already stable through SETUP.
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state    <= IDLE;
      lat_E    <= '0;
      lat_D    <= '0;
      grant_id <= 1'b0;
      err_oor  <= 1'b0;
      rr_pref  <= 1'b0;
      cap_addr <= '0;
      cap_oor  <= 1'b0;
      cnt      <= '0;
    end else begin
      err_oor <= 1'b0;
      case (state)
        IDLE: begin
          if (take0 || take1) begin
            cap_addr <= sel_addr;
            cap_oor  <= sel_oor;
            err_oor  <= sel_oor;
            lat_D    <= sel_data;
            grant_id <= take1;
            rr_pref  <= ~take1;
            state    <= SETUP;
          end
        end
        SETUP: begin
          for (int unsigned i = 0; i < WORDS; i++) begin
            lat_E[i] <= !cap_oor && (cap_addr == AW'(i));
          end
          cnt   <= CW'(PULSE_CYC - 1);
          state <= PULSE;
        end
        PULSE: begin
          if (cnt == '0) begin
            lat_E <= '0;
            cnt   <= CW'(HOLD_CYC - 1);
            state <= HOLD;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        HOLD: begin
          if (cnt == '0) begin
            state <= IDLE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_latch_bank_write_sequencer.sv
// Bench for latch_bank_write_sequencer: scoreboarded enable pulses on a default
// instance plus directed checks on out-of-range and long-pulse instances.
module tb_latch_bank_write_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Instance A: defaults
  logic       a_rn, a_v0, a_v1, a_r0, a_r1, a_busy, a_gid, a_err;
  logic [2:0] a_a0, a_a1;
  logic [7:0] a_d0, a_d1, a_e, a_d;

  latch_bank_write_sequencer dut_a (
    .CLK(clk), .RN(a_rn),
    .req0_valid(a_v0), .req0_ready(a_r0), .req0_addr(a_a0), .req0_data(a_d0),
    .req1_valid(a_v1), .req1_ready(a_r1), .req1_addr(a_a1), .req1_data(a_d1),
    .lat_E(a_e), .lat_D(a_d), .busy(a_busy), .grant_id(a_gid), .err_oor(a_err)
  );

  // Instance B: six words, address space larger than the bank
  logic       b_rn, b_v0, b_v1, b_r0, b_r1, b_busy, b_gid, b_err;
  logic [2:0] b_a0, b_a1;
  logic [7:0] b_d0, b_d1, b_d;
  logic [5:0] b_e;

  latch_bank_write_sequencer #(.WORDS(6), .AW(3), .DW(8), .PULSE_CYC(1), .HOLD_CYC(1)) dut_b (
    .CLK(clk), .RN(b_rn),
    .req0_valid(b_v0), .req0_ready(b_r0), .req0_addr(b_a0), .req0_data(b_d0),
    .req1_valid(b_v1), .req1_ready(b_r1), .req1_addr(b_a1), .req1_data(b_d1),
    .lat_E(b_e), .lat_D(b_d), .busy(b_busy), .grant_id(b_gid), .err_oor(b_err)
  );

  // Instance C: three-cycle pulse, two-cycle hold
  logic       c_rn, c_v0, c_v1, c_r0, c_r1, c_busy, c_gid, c_err;
  logic [2:0] c_a0, c_a1;
  logic [7:0] c_d0, c_d1, c_e, c_d;

  latch_bank_write_sequencer #(.WORDS(8), .AW(3), .DW(8), .PULSE_CYC(3), .HOLD_CYC(2)) dut_c (
    .CLK(clk), .RN(c_rn),
    .req0_valid(c_v0), .req0_ready(c_r0), .req0_addr(c_a0), .req0_data(c_d0),
    .req1_valid(c_v1), .req1_ready(c_r1), .req1_addr(c_a1), .req1_data(c_d1),
    .lat_E(c_e), .lat_D(c_d), .busy(c_busy), .grant_id(c_gid), .err_oor(c_err)
  );

  // Scoreboard for instance A: one entry per expected enable pulse.
  typedef struct {
    logic [7:0] e;
    logic [7:0] d;
    logic       g;
    int         gap;
  } exp_t;

  exp_t q_a[$];

  int         cyc        = 0;
  int         last_start = 0;
  int         plen       = 0;
  bit         in_pulse   = 1'b0;
  logic [7:0] prev_d     = '0;

  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      cyc++;
      if (!a_rn) begin
        in_pulse = 1'b0;
        plen     = 0;
      end else if (a_e != '0) begin
        chk("a_onehot", 32'($onehot(a_e)), 32'd1);
        chk("a_d_steady_in_pulse", 32'(a_d), 32'(prev_d));
        if (!in_pulse) begin
          in_pulse = 1'b1;
          plen     = 1;
          chk("a_sb_nonempty", 32'(q_a.size() != 0), 32'd1);
          if (q_a.size() != 0) begin
            x = q_a.pop_front();
            chk("a_lat_e", 32'(a_e), 32'(x.e));
            chk("a_lat_d", 32'(a_d), 32'(x.d));
            chk("a_grant_id", 32'(a_gid), 32'(x.g));
            if (x.gap != 0) chk("a_pulse_gap", 32'(cyc - last_start), 32'(x.gap));
          end
          last_start = cyc;
        end else begin
          plen++;
        end
      end else if (in_pulse) begin
        chk("a_pulse_len", 32'(plen), 32'd1);
        in_pulse = 1'b0;
      end
      prev_d = a_d;
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    {a_rn, a_v0, a_v1, a_a0, a_a1, a_d0, a_d1} = '0;
    {b_rn, b_v0, b_v1, b_a0, b_a1, b_d0, b_d1} = '0;
    {c_rn, c_v0, c_v1, c_a0, c_a1, c_d0, c_d1} = '0;
    a_v0 = 1'b1;

    // Reset state, ready suppressed while RN low
    @(negedge clk);
    chk("rst_lat_e", 32'(a_e), 32'd0);
    chk("rst_lat_d", 32'(a_d), 32'd0);
    chk("rst_grant", 32'(a_gid), 32'd0);
    chk("rst_err", 32'(a_err), 32'd0);
    chk("rst_busy", 32'(a_busy), 32'd0);
    chk("rst_ready0", 32'(a_r0), 32'd0);
    a_v0 = 1'b0;
    tick();
    a_rn = 1'b1; b_rn = 1'b1; c_rn = 1'b1;
    tick();

    // Single write, then perturb inputs after acceptance
    a_v0 = 1'b1; a_a0 = 3'd3; a_d0 = 8'hA5;
    q_a.push_back('{e: 8'h08, d: 8'hA5, g: 1'b0, gap: 0});
    @(negedge clk);
    chk("sw_ready0", 32'(a_r0), 32'd1);
    chk("sw_ready1", 32'(a_r1), 32'd0);
    chk("sw_busy_idle", 32'(a_busy), 32'd0);
    tick();
    a_a0 = 3'd5; a_d0 = 8'h5A;
    q_a.push_back('{e: 8'h20, d: 8'h5A, g: 1'b0, gap: 4});
    @(negedge clk);
    chk("sw_setup_d", 32'(a_d), 32'hA5);
    chk("sw_setup_e", 32'(a_e), 32'd0);
    chk("sw_setup_busy", 32'(a_busy), 32'd1);
    chk("sw_setup_ready0", 32'(a_r0), 32'd0);
    @(negedge clk);
    chk("sw_pulse_ready0", 32'(a_r0), 32'd0);
    @(negedge clk);
    chk("sw_hold_e", 32'(a_e), 32'd0);
    chk("sw_hold_d", 32'(a_d), 32'hA5);
    chk("sw_hold_ready0", 32'(a_r0), 32'd0);
    chk("sw_hold_busy", 32'(a_busy), 32'd1);
    @(negedge clk);
    chk("sw_idle_busy", 32'(a_busy), 32'd0);
    chk("sw_idle_ready0", 32'(a_r0), 32'd1);
    chk("sw_idle_d", 32'(a_d), 32'hA5);
    tick();
    a_v0 = 1'b0;
    repeat (3) @(negedge clk);
    @(negedge clk);
    chk("pt_busy", 32'(a_busy), 32'd0);
    chk("pt_captured_d", 32'(a_d), 32'h5A);

    // Async reset in the middle of a pulse
    tick();
    a_v1 = 1'b1; a_a1 = 3'd0; a_d1 = 8'h77;
    q_a.push_back('{e: 8'h01, d: 8'h77, g: 1'b1, gap: 0});
    @(negedge clk);
    chk("ar_ready1", 32'(a_r1), 32'd1);
    tick();
    a_v1 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("ar_pulse_e", 32'(a_e), 32'h01);
    #2 a_rn = 1'b0;
    #1;
    chk("ar_lat_e", 32'(a_e), 32'd0);
    chk("ar_lat_d", 32'(a_d), 32'd0);
    chk("ar_busy", 32'(a_busy), 32'd0);
    chk("ar_grant", 32'(a_gid), 32'd0);

    // Contention from reset: grants 0,1,0,1
    @(negedge clk);
    a_v0 = 1'b1; a_a0 = 3'd1; a_d0 = 8'h11;
    a_v1 = 1'b1; a_a1 = 3'd2; a_d1 = 8'h22;
    q_a.push_back('{e: 8'h02, d: 8'h11, g: 1'b0, gap: 0});
    q_a.push_back('{e: 8'h04, d: 8'h22, g: 1'b1, gap: 4});
    q_a.push_back('{e: 8'h02, d: 8'h11, g: 1'b0, gap: 4});
    q_a.push_back('{e: 8'h04, d: 8'h22, g: 1'b1, gap: 4});
    #1;
    chk("rn_low_ready0", 32'(a_r0), 32'd0);
    chk("rn_low_ready1", 32'(a_r1), 32'd0);
    #1 a_rn = 1'b1;
    #1;
    chk("ct_first_ready0", 32'(a_r0), 32'd1);
    chk("ct_first_ready1", 32'(a_r1), 32'd0);
    @(posedge clk);
    repeat (12) @(posedge clk);
    #1;
    a_v0 = 1'b0; a_v1 = 1'b0;
    repeat (5) @(negedge clk);
    chk("ct_busy_end", 32'(a_busy), 32'd0);
    chk("a_sb_drained", 32'(q_a.size()), 32'd0);

    // Out-of-range on six-word bank
    tick();
    b_v1 = 1'b1; b_a1 = 3'd7; b_d1 = 8'h3C;
    @(negedge clk);
    chk("oor_ready1", 32'(b_r1), 32'd1);
    tick();
    b_v1 = 1'b0;
    @(negedge clk);
    chk("oor_err_setup", 32'(b_err), 32'd1);
    chk("oor_e_setup", 32'(b_e), 32'd0);
    chk("oor_d_setup", 32'(b_d), 32'h3C);
    chk("oor_busy", 32'(b_busy), 32'd1);
    @(negedge clk);
    chk("oor_err_pulse", 32'(b_err), 32'd0);
    chk("oor_e_pulse", 32'(b_e), 32'd0);
    @(negedge clk);
    chk("oor_e_hold", 32'(b_e), 32'd0);
    chk("oor_busy_hold", 32'(b_busy), 32'd1);
    @(negedge clk);
    chk("oor_idle", 32'(b_busy), 32'd0);
    chk("oor_err_idle", 32'(b_err), 32'd0);

    // Address == WORDS is out of range
    tick();
    b_v0 = 1'b1; b_a0 = 3'd6; b_d0 = 8'h66;
    tick();
    b_v0 = 1'b0;
    @(negedge clk);
    chk("oor6_err", 32'(b_err), 32'd1);
    @(negedge clk);
    chk("oor6_e", 32'(b_e), 32'd0);
    repeat (2) @(negedge clk);
    chk("oor6_idle", 32'(b_busy), 32'd0);

    // Address == WORDS-1 is in range
    tick();
    b_v0 = 1'b1; b_a0 = 3'd5; b_d0 = 8'h55;
    tick();
    b_v0 = 1'b0;
    @(negedge clk);
    chk("top_err", 32'(b_err), 32'd0);
    @(negedge clk);
    chk("top_e", 32'(b_e), 32'h20);
    chk("top_d", 32'(b_d), 32'h55);
    @(negedge clk);
    chk("top_e_hold", 32'(b_e), 32'd0);
    @(negedge clk);
    chk("top_idle", 32'(b_busy), 32'd0);

    // Long pulse / hold, requester keeps valid high
    tick();
    c_v0 = 1'b1; c_a0 = 3'd7; c_d0 = 8'hC3;
    @(negedge clk);
    chk("lp_ready0", 32'(c_r0), 32'd1);
    tick();
    c_d0 = 8'h00;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      chk($sformatf("lp_e_%0d", k), 32'(c_e), (k >= 1 && k <= 3) ? 32'h80 : 32'h0);
      chk($sformatf("lp_ready_%0d", k), 32'(c_r0), (k == 6) ? 32'd1 : 32'd0);
      chk($sformatf("lp_busy_%0d", k), 32'(c_busy), (k == 6) ? 32'd0 : 32'd1);
      if (k <= 5) chk($sformatf("lp_d_%0d", k), 32'(c_d), 32'hC3);
    end
    #1 c_v0 = 1'b0;
    @(negedge clk);
    chk("lp_no_accept", 32'(c_busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
